// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the instruction memory responder
// Contents: responder FSM state encoding, latency counter width, statistics
// counter width and a saturating increment helper for the statistics counters.
package mem_resp_pkg;

    localparam int LAT_CNT_WIDTH = 8;
    localparam int STAT_WIDTH    = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mem_resp_bram.sv
// rtl/mem_resp_bram.sv - single-port synchronous block RAM with write enable
// Ports:
//   clk, rst  clock and synchronous active-high reset (clears the read register only)
//   en        port enable; with we=1 writes wdata, with we=0 reads into rdata
//   we        write enable
//   addr      word address
//   wdata     write data
//   rdata     registered read data, held until the next read
module mem_resp_bram #(
    parameter int DWIDTH    = 16,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DWIDTH-1:0]    wdata,
    output logic [DWIDTH-1:0]    rdata
);

    (* ramstyle = "block" *) logic [DWIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

    // Array contents are never reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register keeps the last word between reads; reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fixed-latency memory responder for the cache miss port
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/addr    read request, held stable until req_ready is seen
//   req_ready         one-cycle pulse LATENCY cycles after acceptance
//   rsp_data          read word, valid the cycle after req_ready, held afterwards
//   load_valid/addr/data  host RAM fill port, accepted only while load_ready
//   load_ready        high only while idle (combinational)
//   stat_req_count, stat_busy_cycles  only when MEM_RESP_STATS_EN is defined
// Optional feature macro: MEM_RESP_STATS_EN
module instr_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DWIDTH        = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int MEM_ADDR_BITS = 10,
    parameter int LATENCY       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     req_ready,
    output logic [DWIDTH-1:0]        rsp_data,
    input  logic                     load_valid,
    input  logic [MEM_ADDR_BITS-1:0] load_addr,
    input  logic [DWIDTH-1:0]        load_data,
    output logic                     load_ready
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]    stat_req_count,
    output logic [STAT_WIDTH-1:0]    stat_busy_cycles
`endif
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_INIT = LAT_CNT_WIDTH'(LATENCY - 1);

    state_t                   state;
    logic [LAT_CNT_WIDTH-1:0] lat_cnt;
    logic [MEM_ADDR_BITS-1:0] rd_idx;
    logic                     load_fire;
    logic                     req_accept;
    logic                     ram_en;
    logic [MEM_ADDR_BITS-1:0] ram_addr;

    assign load_ready = (state == S_IDLE);
    // A host load wins over a request in the same idle cycle.
    assign load_fire  = (state == S_IDLE) && load_valid;
    assign req_accept = (state == S_IDLE) && !load_valid && req_valid;

    // The port is shared: writes only happen while idle, the read only in S_READY.
    assign ram_en   = load_fire || (state == S_READY);
    assign ram_addr = load_fire ? load_addr : rd_idx;

    mem_resp_bram #(
        .DWIDTH    (DWIDTH),
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_bram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (load_fire),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (rsp_data)
    );

    generate
        if (ADDR_WIDTH > MEM_ADDR_BITS) begin : g_addr_alias
            // Upper request address bits alias onto the RAM.
            logic unused_upper_addr;
            assign unused_upper_addr = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            req_ready <= 1'b0;
            rd_idx    <= '0;
        end else begin
            req_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_accept) begin
                        rd_idx  <= req_addr[MEM_ADDR_BITS-1:0];
                        lat_cnt <= LAT_INIT;
                        if (LATENCY == 1) begin
                            state     <= S_READY;
                            req_ready <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req_valid) begin
                        // Requester withdrew: abandon silently.
                        state   <= S_IDLE;
                        lat_cnt <= '0;
                    end else if (lat_cnt <= LAT_CNT_WIDTH'(1)) begin
                        state     <= S_READY;
                        req_ready <= 1'b1;
                        lat_cnt   <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_CNT_WIDTH'(1);
                    end
                end
                S_READY: begin
                    state <= S_DATA;
                end
                S_DATA: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_RESP_STATS_EN
    // The acceptance cycle counts as busy, so each request costs LATENCY+2 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_count   <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (req_ready) begin
                stat_req_count <= sat_inc(stat_req_count);
            end
            if ((state != S_IDLE) || req_accept) begin
                stat_busy_cycles <= sat_inc(stat_busy_cycles);
            end
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule
